ctrl_rst_sequencer: RTL and testbench
=====================================

Name: ctrl_rst_sequencer

Overview:
- Consumes the 32-bit software control word delivered on user_clk by the a2g_ctrl_rst software register and turns it into a timed, glitch-free reset sequence for the downstream DSP chain.
- Sequence: hold reset for RST_LEN cycles, then wait SETTLE_LEN cycles before declaring done.
- Produces a registered status word for a readback register, including a running count of completed sequences.

Parameters:
RST_LEN, 16, cycles dsp_rst is held high per sequence (>=1)
SETTLE_LEN, 64, cycles after dsp_rst deasserts before done (>=1)
CNT_W, 16, width of completed-sequence counter (<=16)

Ports:
user_clk  in  1  sole clock
user_rst  in  1  synchronous, active-high reset
ctrl_word  in  32  software control word; bit0 rst_req (rising edge), bit1 hold (level), bit2 cnt_clr (rising edge), others ignored
dsp_rst  out  1  registered reset to downstream DSP
seq_busy  out  1  high while in RST or SETTLE
seq_done  out  1  one-cycle pulse on sequence completion
status_word  out  32  [0] busy, [1] dsp_rst, [2] hold, [15:3] zero, [31:16] seq_count (zero-extended)

Behaviour:
- Interface: one clock, user_clk; reset user_rst is synchronous and active-high.
- Input pipeline:
  - ctrl_q <= ctrl_word; ctrl_qq <= ctrl_q; both reset to 0.
  - rise[i] = ctrl_q[i] & ~ctrl_qq[i].
  - A bit already high at reset release produces exactly one rising edge.
- FSM states: IDLE, RST, SETTLE, DONE. One counter cnt, reset to 0 on every state entry.
- Reset values: state=RST, cnt=0, dsp_rst=1, seq_busy=1, seq_done=0, seq_count=0, status_word=0x00000003. A power-on sequence runs automatically after user_rst deasserts.
- IDLE:
  - rise[0] or ctrl_q[1] -> RST.
  - Otherwise stay.
- RST:
  - dsp_rst=1; cnt increments and saturates at RST_LEN-1.
  - rise[0] -> restart at cnt=0.
  - cnt==RST_LEN-1 and ctrl_q[1]==0 -> SETTLE.
  - hold=1 keeps the FSM in RST indefinitely.
- SETTLE:
  - dsp_rst=0; cnt counts 0..SETTLE_LEN-1.
  - rise[0] or ctrl_q[1] -> RST (cnt=0).
  - cnt==SETTLE_LEN-1 -> DONE.
- DONE: exactly one cycle; seq_done=1; seq_count increments (saturating at 2^CNT_W-1); -> IDLE, or -> RST if rise[0] or hold in that cycle.
- Outputs are registered from next-state:
  - dsp_rst = (state==RST).
  - seq_busy = (state==RST or SETTLE).
  - seq_done = (state==DONE).
- Latency:
  - Rising edge of ctrl_word[0] sampled at cycle N -> dsp_rst high from N+2 for exactly RST_LEN cycles.
  - seq_done at N+2+RST_LEN+SETTLE_LEN.
- Hold release: ctrl_word[1] falling at cycle M with RST count saturated -> dsp_rst low at M+2.
- Counter clear: rise[2] zeroes seq_count. Clear and increment in the same cycle -> clear wins (result 0).
- Reset mid-operation: user_rst in any state -> reset values on the next edge; sequence restarts from RST cnt=0.
- status_word is registered from the same next-state values as the other outputs; it is never combinational from ctrl_word.

Decomposition:
- Package ctrl_rst_pkg: state enum; bit indices RST_REQ_BIT=0, HOLD_BIT=1, CNT_CLR_BIT=2; status field positions (BUSY=0, DSPRST=1, HOLD=2, CNT_LSB=16).
- One sub-module, ctrl_edge_det: the two-stage ctrl_word register plus per-bit rising-edge output (width parameterised, 32).
- FSM, counters and status packing stay in ctrl_rst_sequencer.

Test Plan:
- Power-on: user_rst high 4 cycles, ctrl_word=0 -> dsp_rst=1 during reset, then 16 more cycles. seq_busy falls 64 cycles later. One seq_done pulse. status_word=0x00010000 afterwards.
- Pulse request: ctrl_word 0x0->0x1 sampled at cycle N -> dsp_rst rises N+2, falls N+18, seq_done at N+82, count=2. Leaving 0x1 applied produces no further sequence.
- Hold: ctrl_word=0x2 for 200 cycles -> dsp_rst stays 1, status[2]=1. Write 0x0 at M -> dsp_rst 0 at M+2, seq_done 64 cycles later.
- Retrigger in SETTLE: toggle bit0 0->1 at SETTLE cnt=30 -> dsp_rst re-asserts for full 16 cycles. seq_count increments by exactly 1 overall.
- Clear collision: rising edge of bit2 timed so rise[2] coincides with DONE -> seq_count reads 0. Clear in IDLE with count 5 -> 0.
- Reset mid-sequence: user_rst pulsed at SETTLE cnt=40 -> dsp_rst=1 on next edge, count=0, full 16+64 sequence follows.

Source files
------------

// File: rtl/ctrl_rst_sequencer_pkg.sv
// ctrl_rst_pkg: shared states, control bit indices and status field positions
package ctrl_rst_pkg;
  typedef enum logic [1:0] {IDLE, RST, SETTLE, DONE} state_t;
  localparam int RST_REQ_BIT = 0;
  localparam int HOLD_BIT = 1;
  localparam int CNT_CLR_BIT = 2;
  localparam int ST_BUSY = 0;
  localparam int ST_DSPRST = 1;
  localparam int ST_HOLD = 2;
  localparam int ST_CNT_LSB = 16;
endpackage

// File: rtl/ctrl_rst_sequencer_if.sv
// ctrl_rst_if: software control word in, DSP reset and status out
interface ctrl_rst_if;
  logic [31:0] ctrl_word;
  logic dsp_rst;
  logic seq_busy;
  logic seq_done;
  logic [31:0] status_word;
  modport master (output ctrl_word, input dsp_rst, seq_busy, seq_done, status_word);
  modport slave (input ctrl_word, output dsp_rst, seq_busy, seq_done, status_word);
endinterface

// File: rtl/ctrl_rst_sequencer_edge_det.sv
// ctrl_edge_det: two-stage input register with per-bit rising-edge detect
module ctrl_edge_det #(
  parameter int W = 32
) (
  input  logic         user_clk,
  input  logic         user_rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise
);
  logic [W-1:0] qq;
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      q <= '0;
      qq <= '0;
    end else begin
      q <= d;
      qq <= q;
    end
  end
  assign rise = q & ~qq;
endmodule

// File: rtl/ctrl_rst_sequencer.sv
// ctrl_rst_sequencer: timed DSP reset sequence driven by a software control word
module ctrl_rst_sequencer
  import ctrl_rst_pkg::*;
#(
  parameter int RST_LEN = 16,
  parameter int SETTLE_LEN = 64,
  parameter int CNT_W = 16
) (
  input logic     user_clk,
  input logic     user_rst,
  ctrl_rst_if.slave bus
);
  localparam int CW = $clog2((RST_LEN > SETTLE_LEN ? RST_LEN : SETTLE_LEN) + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] count, count_n;
  logic [31:0] ctrl_q, rise, status_n;
  logic req, hold, clr, last_rst, last_set, unused_bits;
  ctrl_edge_det #(.W(32)) u_edge (
    .user_clk(user_clk),
    .user_rst(user_rst),
    .d(bus.ctrl_word),
    .q(ctrl_q),
    .rise(rise)
  );
  assign unused_bits = ^{ctrl_q, rise};
  assign req = rise[RST_REQ_BIT];
  assign hold = ctrl_q[HOLD_BIT];
  assign clr = rise[CNT_CLR_BIT];
  assign last_rst = cnt == CW'(RST_LEN - 1);
  assign last_set = cnt == CW'(SETTLE_LEN - 1);
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    case (state)
      IDLE:    state_n = (req || hold) ? RST : IDLE;
      RST: begin
        state_n = (!req && !hold && last_rst) ? SETTLE : RST;
        cnt_n = req ? '0 : last_rst ? cnt : cnt + 1'b1;
      end
      SETTLE:  state_n = (req || hold) ? RST : last_set ? DONE : SETTLE;
      default: state_n = (req || hold) ? RST : IDLE;
    endcase
    if (state_n != state) cnt_n = '0;
  end
  always_comb begin
    count_n = clr ? '0 : (state == DONE && count != '1) ? count + 1'b1 : count;
    status_n = '0;
    status_n[ST_BUSY] = state_n == RST || state_n == SETTLE;
    status_n[ST_DSPRST] = state_n == RST;
    status_n[ST_HOLD] = hold;
    status_n[ST_CNT_LSB +: CNT_W] = count_n;
  end
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state <= RST;
      cnt <= '0;
      count <= '0;
      bus.dsp_rst <= 1'b1;
      bus.seq_busy <= 1'b1;
      bus.seq_done <= 1'b0;
      bus.status_word <= 32'h3;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      count <= count_n;
      bus.dsp_rst <= state_n == RST;
      bus.seq_busy <= state_n == RST || state_n == SETTLE;
      bus.seq_done <= state_n == DONE;
      bus.status_word <= status_n;
    end
  end
endmodule

// File: tb/tb_ctrl_rst_sequencer.sv
// tb_ctrl_rst_sequencer: directed vector table plus hand-built corner sequences
module tb_ctrl_rst_sequencer;
  typedef struct {
    logic        rst;
    logic [31:0] cw;
    int          n;
    logic        dsp;
    logic        busy;
    logic        done;
    logic [31:0] st;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  vec_t vecs[17];
  ctrl_rst_if bus();
  ctrl_rst_sequencer dut (.user_clk(clk), .user_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic dsp, input logic busy, input logic done,
                         input logic [31:0] st);
    chk({tag, " dsp_rst"}, {31'd0, bus.dsp_rst}, {31'd0, dsp});
    chk({tag, " seq_busy"}, {31'd0, bus.seq_busy}, {31'd0, busy});
    chk({tag, " seq_done"}, {31'd0, bus.seq_done}, {31'd0, done});
    chk({tag, " status"}, bus.status_word, st);
  endtask
  task automatic pulse_seq();
    bus.ctrl_word = 32'h0;
    step(2);
    bus.ctrl_word = 32'h1;
    step(84);
  endtask
  initial begin
    vecs[0]  = '{1'b1, 32'h0, 4,  1'b1, 1'b1, 1'b0, 32'h0000_0003};
    vecs[1]  = '{1'b0, 32'h0, 15, 1'b1, 1'b1, 1'b0, 32'h0000_0003};
    vecs[2]  = '{1'b0, 32'h0, 1,  1'b0, 1'b1, 1'b0, 32'h0000_0001};
    vecs[3]  = '{1'b0, 32'h0, 63, 1'b0, 1'b1, 1'b0, 32'h0000_0001};
    vecs[4]  = '{1'b0, 32'h0, 1,  1'b0, 1'b0, 1'b1, 32'h0000_0000};
    vecs[5]  = '{1'b0, 32'h0, 1,  1'b0, 1'b0, 1'b0, 32'h0001_0000};
    vecs[6]  = '{1'b0, 32'h0, 10, 1'b0, 1'b0, 1'b0, 32'h0001_0000};
    vecs[7]  = '{1'b0, 32'h1, 1,  1'b0, 1'b0, 1'b0, 32'h0001_0000};
    vecs[8]  = '{1'b0, 32'h1, 1,  1'b1, 1'b1, 1'b0, 32'h0001_0003};
    vecs[9]  = '{1'b0, 32'h1, 15, 1'b1, 1'b1, 1'b0, 32'h0001_0003};
    vecs[10] = '{1'b0, 32'h1, 1,  1'b0, 1'b1, 1'b0, 32'h0001_0001};
    vecs[11] = '{1'b0, 32'h1, 63, 1'b0, 1'b1, 1'b0, 32'h0001_0001};
    vecs[12] = '{1'b0, 32'h1, 1,  1'b0, 1'b0, 1'b1, 32'h0001_0000};
    vecs[13] = '{1'b0, 32'h1, 1,  1'b0, 1'b0, 1'b0, 32'h0002_0000};
    vecs[14] = '{1'b0, 32'h1, 20, 1'b0, 1'b0, 1'b0, 32'h0002_0000};
    vecs[15] = '{1'b0, 32'h0, 2,  1'b0, 1'b0, 1'b0, 32'h0002_0000};
    vecs[16] = '{1'b0, 32'h0, 5,  1'b0, 1'b0, 1'b0, 32'h0002_0000};
    bus.ctrl_word = 32'h0;
    for (int i = 0; i < 17; i++) begin
      rst = vecs[i].rst;
      bus.ctrl_word = vecs[i].cw;
      step(vecs[i].n);
      chk_all($sformatf("vec%0d", i), vecs[i].dsp, vecs[i].busy, vecs[i].done, vecs[i].st);
    end
    // hold keeps the sequencer in RST until released
    bus.ctrl_word = 32'h2;
    step(2);
    chk_all("hold_entry", 1'b1, 1'b1, 1'b0, 32'h0002_0007);
    step(198);
    chk_all("hold_200", 1'b1, 1'b1, 1'b0, 32'h0002_0007);
    bus.ctrl_word = 32'h0;
    step(1);
    chk("hold_rel_m1", {31'd0, bus.dsp_rst}, 32'd1);
    step(1);
    chk_all("hold_rel_m2", 1'b0, 1'b1, 1'b0, 32'h0002_0001);
    step(63);
    chk("hold_settle63", {31'd0, bus.seq_done}, 32'd0);
    step(1);
    chk("hold_done", {31'd0, bus.seq_done}, 32'd1);
    step(1);
    chk("hold_count", bus.status_word, 32'h0003_0000);
    // retrigger during SETTLE
    bus.ctrl_word = 32'h1;
    step(5);
    bus.ctrl_word = 32'h0;
    step(41);
    bus.ctrl_word = 32'h1;
    step(2);
    chk_all("retrig_rst", 1'b1, 1'b1, 1'b0, 32'h0003_0003);
    step(15);
    chk("retrig_rst_last", {31'd0, bus.dsp_rst}, 32'd1);
    step(1);
    chk("retrig_rst_end", {31'd0, bus.dsp_rst}, 32'd0);
    step(64);
    chk("retrig_done", {31'd0, bus.seq_done}, 32'd1);
    step(1);
    chk("retrig_count", bus.status_word, 32'h0004_0000);
    // clear edge lands in the DONE cycle
    bus.ctrl_word = 32'h0;
    step(2);
    bus.ctrl_word = 32'h1;
    step(81);
    bus.ctrl_word = 32'h5;
    step(1);
    chk("clr_coll_done", {31'd0, bus.seq_done}, 32'd1);
    step(1);
    chk("clr_coll_count", bus.status_word, 32'h0000_0000);
    for (int i = 0; i < 5; i++) pulse_seq();
    chk("count5", bus.status_word, 32'h0005_0000);
    bus.ctrl_word = 32'h4;
    step(1);
    chk("idle_clr_m1", bus.status_word, 32'h0005_0000);
    step(1);
    chk("idle_clr_m2", bus.status_word, 32'h0000_0000);
    pulse_seq();
    chk("count1", bus.status_word, 32'h0001_0000);
    // user_rst in the middle of SETTLE
    bus.ctrl_word = 32'h0;
    step(2);
    bus.ctrl_word = 32'h1;
    step(58);
    chk_all("mid_settle", 1'b0, 1'b1, 1'b0, 32'h0001_0001);
    rst = 1'b1;
    bus.ctrl_word = 32'h0;
    step(1);
    chk_all("mid_rst", 1'b1, 1'b1, 1'b0, 32'h0000_0003);
    rst = 1'b0;
    step(15);
    chk("rerun_rst_last", {31'd0, bus.dsp_rst}, 32'd1);
    step(1);
    chk("rerun_rst_end", {31'd0, bus.dsp_rst}, 32'd0);
    step(63);
    chk_all("rerun_settle63", 1'b0, 1'b1, 1'b0, 32'h0000_0001);
    step(1);
    chk("rerun_done", {31'd0, bus.seq_done}, 32'd1);
    step(1);
    chk("rerun_count", bus.status_word, 32'h0001_0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
